// File: rtl/ant_world.sv
// Synthesizable maze model that closes the loop around the ant controller.
// Define PHEROMONE_EN to add the pheromone map and the ph_drop/ph_detected ports.
module ant_world #(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 16,
  parameter int unsigned PH_WIDTH  = 2,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 0,
  parameter int unsigned START_DIR = 1,
  parameter int unsigned EXIT_X    = 15,
  parameter int unsigned EXIT_Y    = 15,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  move,
  input  logic                        map_we,
  input  logic [$clog2(GRID_W)-1:0]   map_x,
  input  logic [$clog2(GRID_H)-1:0]   map_y,
  input  logic                        map_wall,
  output logic                        ant_l,
  output logic                        ant_r,
  output logic                        hit,
  output logic                        escape,
  output logic [$clog2(GRID_W)-1:0]   pos_x,
  output logic [$clog2(GRID_H)-1:0]   pos_y,
  output logic [1:0]                  dir,
  output logic [STEP_W-1:0]           step_cnt
`ifdef PHEROMONE_EN
  ,
  input  logic [PH_WIDTH-1:0]         ph_drop,
  output logic [PH_WIDTH-1:0]         ph_detected
`endif
);

  localparam int unsigned Xw       = $clog2(GRID_W);
  localparam int unsigned Yw       = $clog2(GRID_H);
  localparam int unsigned NumCells = GRID_W * GRID_H;

  localparam logic [Xw-1:0] StartX   = Xw'(START_X);
  localparam logic [Yw-1:0] StartY   = Yw'(START_Y);
  localparam logic [1:0]    StartDir = 2'(START_DIR);
  localparam logic [Xw-1:0] ExitX    = Xw'(EXIT_X);
  localparam logic [Yw-1:0] ExitY    = Yw'(EXIT_Y);

  localparam logic [1:0] MvHalt  = 2'b00;
  localparam logic [1:0] MvRight = 2'b01;
  localparam logic [1:0] MvLeft  = 2'b10;
  localparam logic [1:0] MvFwd   = 2'b11;

  if (GRID_W < 4 || GRID_W > 64 || (GRID_W & (GRID_W - 1)) != 0 ||
      GRID_H < 4 || GRID_H > 64 || (GRID_H & (GRID_H - 1)) != 0 ||
      PH_WIDTH == 0 || STEP_W == 0) begin : g_param_check
    $error("ant_world: unsupported parameter set");
  end

  // Neighbour coordinates carry one extra bit so that both underflow and
  // overflow land on a set MSB, which marks the cell as outside the grid.
  function automatic logic [Yw+Xw+1:0] neighbour(input logic [Xw-1:0] x,
                                                  input logic [Yw-1:0] y,
                                                  input logic [1:0]    d);
    logic [Xw:0] nx;
    logic [Yw:0] ny;
    nx = {1'b0, x};
    ny = {1'b0, y};
    unique case (d)
      2'd0: ny = ny - (Yw+1)'(1);
      2'd1: nx = nx + (Xw+1)'(1);
      2'd2: ny = ny + (Yw+1)'(1);
      2'd3: nx = nx - (Xw+1)'(1);
    endcase
    return {ny, nx};
  endfunction

  function automatic logic wall_at(input logic [Yw+Xw+1:0]  c,
                                   input logic [NumCells-1:0] map);
    logic [Xw:0] nx;
    logic [Yw:0] ny;
    nx = c[Xw:0];
    ny = c[Yw+Xw+1:Xw+1];
    if (nx[Xw] || ny[Yw]) return 1'b1;
    return map[{ny[Yw-1:0], nx[Xw-1:0]}];
  endfunction

  logic [Xw-1:0]       pos_x_q, pos_x_d;
  logic [Yw-1:0]       pos_y_q, pos_y_d;
  logic [1:0]          dir_q, dir_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                hit_q, hit_d;
  logic                escape_q, escape_d;
  logic [NumCells-1:0] wall_q, wall_d;
  logic [Yw+Xw+1:0]    ahead, left;
  logic                wr_ok;

  always_comb begin
    ahead = neighbour(pos_x_q, pos_y_q, dir_q);
    left  = neighbour(pos_x_q, pos_y_q, dir_q - 2'd1);
    ant_r = wall_at(ahead, wall_q);
    ant_l = wall_at(left, wall_q);
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    step_d  = step_q;
    hit_d   = 1'b0;
    wall_d  = wall_q;
    if (!escape_q) begin
      if (move != MvHalt && step_q != '1) step_d = step_q + STEP_W'(1);
      unique case (move)
        MvHalt:  ;
        MvRight: dir_d = dir_q + 2'd1;
        MvLeft:  dir_d = dir_q - 2'd1;
        MvFwd: begin
          if (ant_r) begin
            hit_d = 1'b1;
          end else begin
            pos_x_d = ahead[Xw-1:0];
            pos_y_d = ahead[Yw+Xw:Xw+1];
          end
        end
      endcase
    end
    escape_d = escape_q | (pos_x_d == ExitX && pos_y_d == ExitY);
    // A wall may never be dropped onto the ant itself.
    wr_ok = map_we && !(map_wall && map_x == pos_x_q && map_y == pos_y_q);
    if (wr_ok) wall_d[{map_y, map_x}] = map_wall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q  <= StartX;
      pos_y_q  <= StartY;
      dir_q    <= StartDir;
      step_q   <= '0;
      hit_q    <= 1'b0;
      escape_q <= 1'b0;
      wall_q   <= '0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      hit_q    <= hit_d;
      escape_q <= escape_d;
      wall_q   <= wall_d;
    end
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign dir      = dir_q;
  assign step_cnt = step_q;
  assign hit      = hit_q;
  assign escape   = escape_q;

`ifdef PHEROMONE_EN
  logic [PH_WIDTH-1:0] ph_q [NumCells];
  logic [PH_WIDTH-1:0] ph_d [NumCells];

  always_comb begin
    ph_d = ph_q;
    // Deposit goes to the pre-edge cell; a map write to the same cell wins.
    if (!escape_q && ph_drop != '0) ph_d[{pos_y_q, pos_x_q}] = ph_drop;
    if (wr_ok) ph_d[{map_y, map_x}] = '0;
    ph_detected = ph_q[{pos_y_q, pos_x_q}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumCells; i++) ph_q[i] <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end
`endif

endmodule

// File: tb/tb_ant_world.sv
// Scoreboard bench for ant_world: three instances (default, start next to the exit,
// 2-bit step counter); the driver queues expected snapshots, a monitor checks them.
module tb_ant_world;

  localparam logic [1:0] HALT  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] FWD   = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [3];
  logic [1:0] mv_a  [3];
  logic       we_a  [3];
  logic [3:0] mx_a  [3];
  logic [3:0] my_a  [3];
  logic       mw_a  [3];
  logic       al [3];
  logic       ar [3];
  logic       hit [3];
  logic       esc [3];
  logic [3:0] px [3];
  logic [3:0] py [3];
  logic [1:0] dr [3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;
`ifdef PHEROMONE_EN
  logic [1:0] phd_a [3];
  logic [1:0] phdet [3];
`endif

  // Pending map write / pheromone drop applied by the next act() call.
  logic       pw;
  logic [3:0] pmx, pmy;
  logic       pmw;
  logic [1:0] pdrop;

  typedef struct {
    int          cyc;
    int          which;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  ant_world dut0 (
    .clk(clk), .rst_n(rst_a[0]), .move(mv_a[0]), .map_we(we_a[0]), .map_x(mx_a[0]),
    .map_y(my_a[0]), .map_wall(mw_a[0]), .ant_l(al[0]), .ant_r(ar[0]), .hit(hit[0]),
    .escape(esc[0]), .pos_x(px[0]), .pos_y(py[0]), .dir(dr[0]), .step_cnt(sc0)
`ifdef PHEROMONE_EN
    , .ph_drop(phd_a[0]), .ph_detected(phdet[0])
`endif
  );

  ant_world #(.START_X(14), .START_Y(15)) dut1 (
    .clk(clk), .rst_n(rst_a[1]), .move(mv_a[1]), .map_we(we_a[1]), .map_x(mx_a[1]),
    .map_y(my_a[1]), .map_wall(mw_a[1]), .ant_l(al[1]), .ant_r(ar[1]), .hit(hit[1]),
    .escape(esc[1]), .pos_x(px[1]), .pos_y(py[1]), .dir(dr[1]), .step_cnt(sc1)
`ifdef PHEROMONE_EN
    , .ph_drop(phd_a[1]), .ph_detected(phdet[1])
`endif
  );

  ant_world #(.STEP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_a[2]), .move(mv_a[2]), .map_we(we_a[2]), .map_x(mx_a[2]),
    .map_y(my_a[2]), .map_wall(mw_a[2]), .ant_l(al[2]), .ant_r(ar[2]), .hit(hit[2]),
    .escape(esc[2]), .pos_x(px[2]), .pos_y(py[2]), .dir(dr[2]), .step_cnt(sc2)
`ifdef PHEROMONE_EN
    , .ph_drop(phd_a[2]), .ph_detected(phdet[2])
`endif
  );

  // Snapshot layout: {x, y, dir, steps, hit, escape, ant_l, ant_r, ph}.
  function automatic logic [31:0] actual(input int w);
    logic [15:0] s;
    logic [1:0]  p;
    s = (w == 0) ? sc0 : (w == 1) ? sc1 : {14'd0, sc2};
    p = 2'd0;
`ifdef PHEROMONE_EN
    p = phdet[w];
`endif
    return {px[w], py[w], dr[w], s, hit[w], esc[w], al[w], ar[w], p};
  endfunction

  task automatic act(input int w, input logic rv, input logic [1:0] m, input string nm,
                     input int x, input int y, input int d, input int s, input int h,
                     input int e, input int l, input int r, input int p);
    exp_t t;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mv_a[i] = HALT;
      we_a[i] = 1'b0;
`ifdef PHEROMONE_EN
      phd_a[i] = 2'd0;
`endif
    end
    rst_a[w] = rv;
    mv_a[w]  = m;
    we_a[w]  = pw;
    mx_a[w]  = pmx;
    my_a[w]  = pmy;
    mw_a[w]  = pmw;
`ifdef PHEROMONE_EN
    phd_a[w] = pdrop;
`endif
    pw    = 1'b0;
    pdrop = 2'd0;
    t.cyc   = cyc + 1;
    t.which = w;
    t.name  = nm;
    t.exp   = {4'(x), 4'(y), 2'(d), 16'(s), 1'(h), 1'(e), 1'(l), 1'(r), 2'(p)};
    sb.push_back(t);
  endtask

  task automatic map_wr(input int x, input int y, input logic wall);
    pw  = 1'b1;
    pmx = 4'(x);
    pmy = 4'(y);
    pmw = wall;
  endtask

  // Monitor: checks every queued snapshot whose cycle has come.
  initial begin
    exp_t        e;
    logic [31:0] a, m;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        a = actual(e.which);
        m = e.exp;
`ifndef PHEROMONE_EN
        a[1:0] = 2'd0;
        m[1:0] = 2'd0;
`endif
        n_tests++;
        if (e.cyc != cyc || a !== m) begin
          n_fail++;
          $display("FAIL %s (dut%0d): got {x,y,dir,steps,hit,esc,l,r,ph}=%h required %h",
                   e.name, e.which, a, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0;
      mv_a[i]  = HALT;
      we_a[i]  = 1'b0;
      mx_a[i]  = 4'd0;
      my_a[i]  = 4'd0;
      mw_a[i]  = 1'b0;
`ifdef PHEROMONE_EN
      phd_a[i] = 2'd0;
`endif
    end
    pw = 1'b0; pmx = 4'd0; pmy = 4'd0; pmw = 1'b0; pdrop = 2'd0;

    //   dut rst move  name         x  y  d  s  h  e  l  r  ph
    act(0, 0, HALT,  "reset0",     0, 0, 1, 0, 0, 0, 1, 0, 0);
    act(1, 0, HALT,  "reset1",    14,15, 1, 0, 0, 0, 0, 0, 0);
    act(2, 0, HALT,  "reset2",     0, 0, 1, 0, 0, 0, 1, 0, 0);

    act(0, 1, FWD,   "fwd1",       1, 0, 1, 1, 0, 0, 1, 0, 0);
    act(0, 1, FWD,   "fwd2",       2, 0, 1, 2, 0, 0, 1, 0, 0);
    act(0, 1, FWD,   "fwd3",       3, 0, 1, 3, 0, 0, 1, 0, 0);
    act(0, 0, HALT,  "mid_reset",  0, 0, 1, 0, 0, 0, 1, 0, 0);
    map_wr(1, 0, 1'b1);
    act(0, 1, HALT,  "wall_wr",    0, 0, 1, 0, 0, 0, 1, 1, 0);
    act(0, 1, FWD,   "blocked",    0, 0, 1, 1, 1, 0, 1, 1, 0);
    map_wr(1, 0, 1'b0);
    act(0, 1, HALT,  "hit_clear",  0, 0, 1, 1, 0, 0, 1, 0, 0);
    act(0, 1, RIGHT, "right1",     0, 0, 2, 2, 0, 0, 0, 0, 0);
    act(0, 1, RIGHT, "right2",     0, 0, 3, 3, 0, 0, 0, 1, 0);
    act(0, 1, RIGHT, "right3",     0, 0, 0, 4, 0, 0, 1, 1, 0);
    act(0, 1, RIGHT, "right4",     0, 0, 1, 5, 0, 0, 1, 0, 0);
    act(0, 1, LEFT,  "left1",      0, 0, 0, 6, 0, 0, 1, 1, 0);
    map_wr(0, 0, 1'b1);
    act(0, 1, HALT,  "self_wall",  0, 0, 0, 6, 0, 0, 1, 1, 0);
    act(0, 1, RIGHT, "right5",     0, 0, 1, 7, 0, 0, 1, 0, 0);
    act(0, 1, FWD,   "move_out",   1, 0, 1, 8, 0, 0, 1, 0, 0);
    act(0, 1, LEFT,  "left2",      1, 0, 0, 9, 0, 0, 0, 1, 0);
    act(0, 1, LEFT,  "left3",      1, 0, 3,10, 0, 0, 0, 0, 0);
    act(0, 1, FWD,   "move_back",  0, 0, 3,11, 0, 0, 0, 1, 0);
    act(0, 1, RIGHT, "right6",     0, 0, 0,12, 0, 0, 1, 1, 0);
    act(0, 1, RIGHT, "right7",     0, 0, 1,13, 0, 0, 1, 0, 0);
    map_wr(1, 0, 1'b1);
    act(0, 1, FWD,   "wr_vs_move", 1, 0, 1,14, 0, 0, 1, 0, 0);
    act(0, 1, LEFT,  "left4",      1, 0, 0,15, 0, 0, 0, 1, 0);
    act(0, 1, LEFT,  "left5",      1, 0, 3,16, 0, 0, 0, 0, 0);
    act(0, 1, FWD,   "move_back2", 0, 0, 3,17, 0, 0, 0, 1, 0);
    act(0, 1, RIGHT, "right8",     0, 0, 0,18, 0, 0, 1, 1, 0);
    act(0, 1, RIGHT, "right9",     0, 0, 1,19, 0, 0, 1, 1, 0);
    act(0, 1, FWD,   "blocked2",   0, 0, 1,20, 1, 0, 1, 1, 0);
    act(0, 0, HALT,  "reset_map",  0, 0, 1, 0, 0, 0, 1, 0, 0);
`ifdef PHEROMONE_EN
    pdrop = 2'd1;
    act(0, 1, FWD,   "ph_fwd",     1, 0, 1, 1, 0, 0, 1, 0, 0);
    act(0, 1, LEFT,  "ph_left1",   1, 0, 0, 2, 0, 0, 0, 1, 0);
    act(0, 1, LEFT,  "ph_left2",   1, 0, 3, 3, 0, 0, 0, 0, 0);
    act(0, 1, FWD,   "ph_back",    0, 0, 3, 4, 0, 0, 0, 1, 1);
    map_wr(0, 0, 1'b0);
    act(0, 1, HALT,  "ph_clear",   0, 0, 3, 4, 0, 0, 0, 1, 0);
`else
    act(0, 1, FWD,   "fwd_rst_map",1, 0, 1, 1, 0, 0, 1, 0, 0);
`endif

    act(1, 1, HALT,  "d1_halt",   14,15, 1, 0, 0, 0, 0, 0, 0);
    act(1, 1, FWD,   "d1_exit",   15,15, 1, 1, 0, 1, 0, 1, 0);
    act(1, 1, FWD,   "d1_frz_fwd",15,15, 1, 1, 0, 1, 0, 1, 0);
    act(1, 1, RIGHT, "d1_frz_rt", 15,15, 1, 1, 0, 1, 0, 1, 0);
    act(1, 0, HALT,  "d1_reset",  14,15, 1, 0, 0, 0, 0, 0, 0);
    act(1, 1, HALT,  "d1_release",14,15, 1, 0, 0, 0, 0, 0, 0);

    act(2, 1, RIGHT, "sat_r1",     0, 0, 2, 1, 0, 0, 0, 0, 0);
    act(2, 1, RIGHT, "sat_r2",     0, 0, 3, 2, 0, 0, 0, 1, 0);
    act(2, 1, RIGHT, "sat_r3",     0, 0, 0, 3, 0, 0, 1, 1, 0);
    act(2, 1, RIGHT, "sat_r4",     0, 0, 1, 3, 0, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
